// File: rtl/checker_pkg.sv
// Shared types for the writeback commit checker: run-control FSM encoding.
// Entry layout is declared beside its widths in the top module.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow architectural register file: one write port, one combinational read port, x0 reads 0.
// Writes land at the clock edge; no backpressure, clr wins over a write in the same cycle.
module shadow_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : regs[raddr];

endmodule

// File: rtl/regfile_commit_checker.sv
// Commit monitor: shadows writebacks for a run window, then checks one expectation slot per cycle.
// start-to-done is RUN_CYCLES+MAX_CHECKS+1 cycles; never stalls the core, table writes ignored while busy.
module regfile_commit_checker
  import checker_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 8,
  parameter int RA_W       = $clog2(NUM_REGS),
  parameter int MAX_CHECKS = 8,
  parameter int IX_W       = $clog2(MAX_CHECKS),
  parameter int RUN_CYCLES = 70,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exp_we,
  input  logic [IX_W-1:0]   exp_idx,
  input  logic              exp_en,
  input  logic [RA_W-1:0]   exp_rd,
  input  logic [DATA_W-1:0] exp_val,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IX_W:0]     mismatch_count,
  output logic              fail_valid,
  output logic [RA_W-1:0]   fail_rd,
  output logic [DATA_W-1:0] fail_got,
  output logic [DATA_W-1:0] fail_exp,
  output logic [CNT_W-1:0]  commit_count
);

  localparam int CYC_W = $clog2(RUN_CYCLES + 1);

  typedef struct packed {
    logic              en;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] val;
  } exp_entry_t;

  chk_state_t        state, state_n;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [IX_W-1:0]   chk_idx;
  exp_entry_t        tbl [MAX_CHECKS];
  exp_entry_t        cur;
  logic [DATA_W-1:0] shadow_val;
  logic              idle_or_done;
  logic              start_go;
  logic              run_term;
  logic              chk_last;
  logic              slot_bad;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign start_go     = start && idle_or_done;
  assign run_term     = (cyc_cnt == CYC_W'(RUN_CYCLES - 1));
  assign chk_last     = (chk_idx == IX_W'(MAX_CHECKS - 1));
  assign cur          = tbl[chk_idx];
  assign slot_bad     = (state == CHECK) && cur.en && (shadow_val != cur.val);

  shadow_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .RA_W    (RA_W)
  ) u_shadow (
    .clk  (clk),
    .clr  (reset || start_go),
    .we   ((state == RUN) && wb_we),
    .waddr(wb_rd),
    .wdata(wb_data),
    .raddr(cur.rd),
    .rdata(shadow_val)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (stop || run_term) state_n = CHECK;
      CHECK:   if (chk_last) state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt        <= '0;
      chk_idx        <= '0;
      commit_count   <= '0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_rd        <= '0;
      fail_got       <= '0;
      fail_exp       <= '0;
      for (int i = 0; i < MAX_CHECKS; i++) tbl[i] <= '0;
    end else begin
      if (start_go) begin
        cyc_cnt        <= '0;
        chk_idx        <= '0;
        commit_count   <= '0;
        mismatch_count <= '0;
        fail_valid     <= 1'b0;
        fail_rd        <= '0;
        fail_got       <= '0;
        fail_exp       <= '0;
      end
      if (state == RUN) begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (wb_we && (commit_count != '1)) commit_count <= commit_count + 1'b1;
      end
      if (state == CHECK) begin
        chk_idx <= chk_idx + 1'b1;
        if (slot_bad) begin
          mismatch_count <= mismatch_count + 1'b1;
          // only the first failing slot is kept for debug
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_rd    <= cur.rd;
            fail_got   <= shadow_val;
            fail_exp   <= cur.val;
          end
        end
      end
      if (exp_we && idle_or_done) begin
        tbl[exp_idx] <= '{en: exp_en, rd: exp_rd, val: exp_val};
      end
    end
  end

  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (mismatch_count == '0);

endmodule

// File: tb/tb_regfile_commit_checker.sv
// Randomized and directed bench for regfile_commit_checker against a behavioural model.
module tb_regfile_commit_checker;

  localparam int RUNC  = 70;
  localparam int MAXC  = 8;
  localparam int NREGS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_rd = '0;
  logic [15:0] wb_data = '0;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_idx = '0;
  logic        exp_en = 1'b0;
  logic [2:0]  exp_rd = '0;
  logic [15:0] exp_val = '0;
  logic        busy, done, pass, fail_valid;
  logic [3:0]  mismatch_count;
  logic [2:0]  fail_rd;
  logic [15:0] fail_got, fail_exp, commit_count;

  regfile_commit_checker dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_en(exp_en), .exp_rd(exp_rd), .exp_val(exp_val),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .fail_valid(fail_valid), .fail_rd(fail_rd), .fail_got(fail_got), .fail_exp(fail_exp),
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_sh [NREGS];
  bit m_en [MAXC];
  int m_rd [MAXC];
  int m_val[MAXC];
  int m_run_left = 0, m_check_left = 0;
  bit m_done = 0;
  int m_cc = 0, m_mm = 0;
  bit m_fv = 0;
  int m_frd = 0, m_fgot = 0, m_fexp = 0;

  function automatic void m_clear_results();
    foreach (m_sh[i]) m_sh[i] = 0;
    m_cc = 0; m_mm = 0; m_fv = 0; m_frd = 0; m_fgot = 0; m_fexp = 0; m_done = 0;
  endfunction

  function automatic void m_evaluate();
    for (int i = 0; i < MAXC; i++) begin
      int got;
      if (!m_en[i]) continue;
      got = (m_rd[i] == 0) ? 0 : m_sh[m_rd[i]];
      if (got != m_val[i]) begin
        m_mm++;
        if (!m_fv) begin m_fv = 1; m_frd = m_rd[i]; m_fgot = got; m_fexp = m_val[i]; end
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_clear_results();
      foreach (m_en[i]) begin m_en[i] = 0; m_rd[i] = 0; m_val[i] = 0; end
      m_run_left = 0; m_check_left = 0;
    end else if (m_run_left > 0) begin
      if (wb_we) begin
        if (m_cc < 65535) m_cc++;
        if (wb_rd != 0) m_sh[wb_rd] = wb_data;
      end
      m_run_left = stop ? 0 : m_run_left - 1;
      if (m_run_left == 0) m_check_left = MAXC;
    end else if (m_check_left > 0) begin
      m_check_left--;
      if (m_check_left == 0) begin m_done = 1; m_evaluate(); end
    end else begin
      if (exp_we) begin m_en[exp_idx] = exp_en; m_rd[exp_idx] = exp_rd; m_val[exp_idx] = exp_val; end
      if (start) begin m_clear_results(); m_run_left = RUNC; end
    end
  end

  // Results are only stable outside the slot-walk phase.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", busy, int'(m_run_left > 0 || m_check_left > 0));
      chk("done", done, int'(m_done));
      chk("commit_count", commit_count, m_cc);
      if (m_check_left == 0) begin
        chk("pass", pass, int'(m_done && m_mm == 0));
        chk("mismatch_count", mismatch_count, m_mm);
        chk("fail_valid", fail_valid, int'(m_fv));
        chk("fail_rd", fail_rd, m_frd);
        chk("fail_got", fail_got, m_fgot);
        chk("fail_exp", fail_exp, m_fexp);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit          s_we [128];
  logic [2:0]  s_rd [128];
  logic [15:0] s_dat[128];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 128; i++) begin s_we[i] = 0; s_rd[i] = '0; s_dat[i] = '0; end
  endtask

  task automatic sched(input int cyc, input int rd, input int dat);
    s_we[cyc] = 1; s_rd[cyc] = 3'(rd); s_dat[cyc] = 16'(dat);
  endtask

  task automatic prog(input int idx, input bit en, input int rd, input int val);
    exp_we = 1; exp_idx = 3'(idx); exp_en = en; exp_rd = 3'(rd); exp_val = 16'(val);
    tick();
    exp_we = 0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < MAXC; i++) prog(i, 0, 0, 0);
  endtask

  // Returns the cycle (start cycle = 0) in which done is first seen, or the reset cycle + 1.
  task automatic run(input int stop_cyc, input int rst_cyc, input bit junk_we, output int cyc);
    start = 1; wb_we = 1; wb_rd = 3'($urandom_range(1, 7)); wb_data = 16'hDEAD;
    tick();
    start = 0; wb_we = 0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (s_we[cyc]) begin wb_we = 1; wb_rd = s_rd[cyc]; wb_data = s_dat[cyc]; end
      else begin wb_we = 0; wb_rd = 3'($urandom_range(0, 7)); wb_data = 16'($urandom); end
      stop  = (cyc == stop_cyc);
      reset = (cyc == rst_cyc);
      if (junk_we) begin
        exp_we = 1; exp_idx = 3'($urandom_range(0, 7)); exp_en = 1;
        exp_rd = 3'($urandom_range(0, 7)); exp_val = 16'hBEEF;
      end
      tick();
      wb_we = 0; stop = 0; exp_we = 0;
      cyc++;
      if (reset) begin reset = 0; return; end
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic prog_nominal();
    prog(0, 1, 1, 'h00FF); prog(1, 1, 2, 'h00F0); prog(2, 1, 4, 'h000F);
    prog(3, 1, 7, 'h000F); prog(4, 1, 3, 'h00F0); prog(5, 1, 6, 'h00FA);
    prog(6, 1, 5, 'h00FF); prog(7, 0, 0, 0);
  endtask

  task automatic sched_nominal(input int x6val);
    clear_sched();
    sched(3, 1, 'h00FF); sched(8, 2, 'h00F0); sched(13, 4, 'h000F); sched(18, 7, 'h000F);
    sched(23, 3, 'h00F0); sched(28, 6, x6val); sched(RUNC, 5, 'h00FF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    tick(); tick();
    reset = 0;
    cmp_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mismatch", mismatch_count, 0);

    // Nominal pass, last commit lands in the final RUN cycle.
    prog_nominal(); sched_nominal('h00FA);
    run(0, 0, 0, cyc);
    chk("nom_latency", cyc, RUNC + MAXC + 1);
    chk("nom_pass", pass, 1);
    chk("nom_mm", mismatch_count, 0);
    chk("nom_cc", commit_count, 7);

    // Single mismatch on x6.
    sched_nominal('h00F2);
    run(0, 0, 0, cyc);
    chk("mm_pass", pass, 0);
    chk("mm_count", mismatch_count, 1);
    chk("mm_rd", fail_rd, 6);
    chk("mm_got", fail_got, 'h00F2);
    chk("mm_exp", fail_exp, 'h00FA);

    // x0 write is counted but not stored; later write to x3 wins.
    clear_table(); prog(0, 1, 0, 0); prog(1, 1, 3, 'h00F0);
    clear_sched(); sched(2, 0, 'h1234); sched(3, 3, 'h0011); sched(4, 3, 'h00F0);
    run(0, 0, 0, cyc);
    chk("x0_pass", pass, 1);
    chk("x0_cc", commit_count, 3);

    // Early stop in RUN cycle 10 with a commit in that same cycle.
    clear_table(); prog(0, 1, 2, 'h00F0);
    clear_sched(); sched(10, 2, 'h00F0);
    run(10, 0, 0, cyc);
    chk("stop_latency", cyc, 10 + MAXC + 1);
    chk("stop_pass", pass, 1);
    chk("stop_cc", commit_count, 1);

    // Table writes while busy are dropped.
    prog_nominal(); sched_nominal('h00FA);
    run(0, 0, 1, cyc);
    chk("ill_latency", cyc, RUNC + MAXC + 1);
    chk("ill_pass", pass, 1);
    chk("ill_mm", mismatch_count, 0);
    chk("ill_cc", commit_count, 7);

    // Reset during CHECK, then re-run with the now-empty table.
    sched_nominal('h1111);
    run(0, RUNC + 4, 0, cyc);
    chk("rstchk_busy", busy, 0);
    chk("rstchk_done", done, 0);
    chk("rstchk_cc", commit_count, 0);
    chk("rstchk_fv", fail_valid, 0);
    run(0, 0, 0, cyc);
    chk("rstchk_rerun_pass", pass, 1);
    chk("rstchk_rerun_cc", commit_count, 7);

    // Randomized runs checked by the model.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < MAXC; i++)
        prog(i, bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3));
      clear_sched();
      for (int c = 1; c <= RUNC; c++)
        if ($urandom_range(0, 2) == 0) sched(c, $urandom_range(0, 7), $urandom_range(0, 3));
      run(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, RUNC), 0,
          bit'($urandom_range(0, 1)), cyc);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
